// File: rtl/adc_dma_framer.sv
// ADC-to-AXI-Stream framer: converts two offset-binary ADC channels to signed
// 16-bit, optionally decimates, and emits fixed-length tlast-terminated frames.
module adc_dma_framer #(
    parameter int unsigned ADC_WIDTH  = 14,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                 adc_clock,
    input  logic                 adc_rst_n,
    input  logic [ADC_WIDTH-1:0] adc_dat_a_i,
    input  logic [ADC_WIDTH-1:0] adc_dat_b_i,
    input  logic                 arm_i,
    input  logic [LEN_WIDTH-1:0] frame_len_i,
    input  logic [LEN_WIDTH-1:0] decim_i,
    output logic [31:0]          m_axis_tdata,
    output logic [3:0]           m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o
);

    localparam int unsigned SAMP_W = 16;
    localparam int unsigned EXT_W  = SAMP_W - ADC_WIDTH;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WORD_W = 2 * SAMP_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SAMP_W-1:0]     r_a;
    logic [SAMP_W-1:0]     r_b;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_dec;
    logic [LEN_WIDTH-1:0]  r_beat;
    logic [LEN_WIDTH-1:0]  r_dcnt;
    logic                  r_ovf;
    logic                  r_done;
    logic [WORD_W-1:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic [31:0]           r_tdata;
    logic                  r_tlast;
    logic                  r_tvalid;

    logic [ADC_WIDTH-1:0]  w_a_conv;
    logic [ADC_WIDTH-1:0]  w_b_conv;
    logic [CNT_W-1:0]      w_occ;
    logic                  w_full;
    logic                  w_last;
    logic                  w_load;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_done;
    logic                  w_mem_rd;

    // Offset binary to two's complement: keep MSB, invert the rest
    assign w_a_conv = {adc_dat_a_i[ADC_WIDTH-1], ~adc_dat_a_i[ADC_WIDTH-2:0]};
    assign w_b_conv = {adc_dat_b_i[ADC_WIDTH-1], ~adc_dat_b_i[ADC_WIDTH-2:0]};

    // Occupancy counts the output register too, so total storage is FIFO_DEPTH
    assign w_occ    = r_cnt + CNT_W'(r_tvalid);
    assign w_full   = (w_occ == CNT_W'(FIFO_DEPTH));
    assign w_last   = (r_beat == r_len - LEN_WIDTH'(1));
    assign w_mem_rd = (r_cnt != '0) && (!r_tvalid || m_axis_tready);

    always_ff @(posedge adc_clock or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_push      = 1'b0;
        w_drop      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (arm_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (r_dcnt == '0) begin
                    if (w_full) begin
                        w_drop = 1'b1;
                    end else begin
                        w_push = 1'b1;
                        if (w_last) begin
                            w_state_nxt = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (r_tvalid && m_axis_tready && r_tlast) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge adc_clock or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_len  <= '0;
            r_dec  <= '0;
            r_beat <= '0;
            r_dcnt <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_a    <= {{EXT_W{w_a_conv[ADC_WIDTH-1]}}, w_a_conv};
            r_b    <= {{EXT_W{w_b_conv[ADC_WIDTH-1]}}, w_b_conv};
            r_done <= w_done;
            if (w_load) begin
                r_len  <= (frame_len_i == '0) ? LEN_WIDTH'(1) : frame_len_i;
                r_dec  <= decim_i;
                r_beat <= '0;
                r_dcnt <= '0;
                r_ovf  <= 1'b0;
            end else if (r_state == S_CAPTURE) begin
                r_dcnt <= (r_dcnt == r_dec) ? '0 : r_dcnt + LEN_WIDTH'(1);
                if (w_push) begin
                    r_beat <= r_beat + LEN_WIDTH'(1);
                end
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge adc_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_last, r_b, r_a};
        end
    end

    // FIFO pointers plus a registered output stage that refills whenever it frees up
    always_ff @(posedge adc_clock or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_mem_rd);
            if (w_mem_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_tdata  <= r_mem[r_rd_ptr][31:0];
                r_tlast  <= r_mem[r_rd_ptr][WORD_W-1];
                r_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = 4'hF;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tvalid = r_tvalid;
    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = r_done;
    assign overflow_o    = r_ovf;

endmodule

// File: tb/tb_adc_dma_framer.sv
// Self-checking bench for adc_dma_framer: frame table plus directed corner
// sequences, every cycle compared against a queue-based reference model.
module tb_adc_dma_framer;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] dat_a = '0;
    logic [13:0] dat_b = '0;
    logic        arm = 1'b0;
    logic [15:0] frame_len = '0;
    logic [15:0] decim = '0;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        busy;
    logic        done;
    logic        ovf;

    adc_dma_framer dut (
        .adc_clock     (clk),
        .adc_rst_n     (rst_n),
        .adc_dat_a_i   (dat_a),
        .adc_dat_b_i   (dat_b),
        .arm_i         (arm),
        .frame_len_i   (frame_len),
        .decim_i       (decim),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tlast  (tlast),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .busy_o        (busy),
        .done_o        (done),
        .overflow_o    (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int step_cnt = 0;

    // Reference model: frame controller and a queue of beats not yet accepted
    int          m_state;   // 0 idle, 1 capture, 2 drain
    int unsigned m_len, m_dec, m_beat, m_dcnt;
    bit          m_ovf, m_done, m_hold;
    logic [15:0] m_sa, m_sb;
    logic [32:0] q[$];
    int          m_acc, m_lasts, first_step;
    logic [31:0] first_data;

    function automatic logic [15:0] conv(input logic [13:0] d);
        int v;
        v = 8191 - int'(d);
        return 16'(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, step_cnt);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_len = 0; m_dec = 0; m_beat = 0; m_dcnt = 0;
        m_ovf = 0; m_done = 0; m_hold = 0; m_sa = '0; m_sb = '0;
        q.delete();
    endtask

    // Effect of the coming clock edge, using the inputs currently driven
    task automatic model_update();
        bit pop;
        pop    = tvalid && tready && (q.size() > 0);
        m_hold = tvalid && !tready;
        m_done = 0;
        case (m_state)
            0: if (arm) begin
                m_len = (frame_len == 0) ? 1 : int'(frame_len);
                m_dec = int'(decim);
                m_beat = 0; m_dcnt = 0; m_ovf = 0; m_state = 1;
            end
            1: begin
                if (m_dcnt == 0) begin
                    if (q.size() < DEPTH) begin
                        q.push_back({(m_beat == m_len - 1) ? 1'b1 : 1'b0, m_sb, m_sa});
                        if (m_beat == m_len - 1) m_state = 2;
                        m_beat++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                m_dcnt = (m_dcnt == m_dec) ? 0 : m_dcnt + 1;
            end
            default: if (pop && q[0][32]) begin
                m_done = 1; m_state = 0;
            end
        endcase
        if (pop) begin
            m_acc++;
            if (q[0][32]) m_lasts++;
            void'(q.pop_front());
        end
        m_sa = conv(dat_a);
        m_sb = conv(dat_b);
    endtask

    task automatic check_outputs();
        chk("busy", 64'(busy), 64'(m_state != 0));
        chk("done", 64'(done), 64'(m_done));
        chk("overflow", 64'(ovf), 64'(m_ovf));
        chk("tkeep", 64'(tkeep), 64'h F);
        if (m_hold) chk("tvalid_hold", 64'(tvalid), 64'd1);
        if (tvalid) begin
            if (first_step < 0) begin
                first_step = step_cnt;
                first_data = tdata;
            end
            if (q.size() == 0) begin
                chk("spurious_beat", 64'(tvalid), 64'd0);
            end else begin
                chk("tdata", 64'(tdata), 64'(q[0][31:0]));
                chk("tlast", 64'(tlast), 64'(q[0][32]));
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
        step_cnt++;
        check_outputs();
    endtask

    typedef struct {
        int          a_mode;     // 0 const, 1 ramp, 2 random
        logic [13:0] a_val;
        logic [13:0] b_val;
        int          len;
        int          dec;
        int          rdy_mode;   // 0 always, 1 stall 40 cycles, 2 random
        bit          chk_first;
        logic [31:0] exp_first;
        int          exp_beats;
        int          exp_ovf;    // 2 = not predetermined
    } frame_vec_t;

    frame_vec_t tbl[6];

    task automatic run_frame(input frame_vec_t v);
        int n;
        int arm_step;
        m_acc = 0; m_lasts = 0; first_step = -1;
        dat_a = (v.a_mode == 2) ? 14'($urandom) : v.a_val;
        dat_b = (v.a_mode == 2) ? 14'($urandom) : v.b_val;
        frame_len = 16'(v.len);
        decim = 16'(v.dec);
        tready = (v.rdy_mode == 0) ? 1'b1 : (v.rdy_mode == 2) ? 1'($urandom) : 1'b0;
        arm = 1'b1;
        arm_step = step_cnt;
        tick();
        arm = 1'b0;
        n = 0;
        while (m_state != 0 && n < 3000) begin
            n++;
            if (v.a_mode == 1) dat_a = dat_a + 14'd1;
            if (v.a_mode == 2) begin
                dat_a = 14'($urandom);
                dat_b = 14'($urandom);
            end
            frame_len = 16'($urandom);
            decim = 16'($urandom);
            case (v.rdy_mode)
                0: tready = 1'b1;
                1: tready = (n >= 40);
                default: tready = 1'($urandom);
            endcase
            tick();
        end
        chk("frame_timeout", 64'(n < 3000), 64'd1);
        chk("beats", 64'(m_acc), 64'(v.exp_beats));
        chk("tlast_count", 64'(m_lasts), 64'd1);
        chk("first_latency", 64'(first_step - arm_step), 64'd3);
        if (v.chk_first) chk("first_data", 64'(first_data), 64'(v.exp_first));
        if (v.exp_ovf != 2) chk("frame_overflow", 64'(ovf), 64'(v.exp_ovf));
        tready = 1'b1;
        tick();
    endtask

    initial begin
        //          mode a_val    b_val    len  dec rdy first first_data    beats ovf
        tbl[0] = '{0, 14'h0000, 14'h3FFF, 8,   0, 0, 1, 32'hE000_1FFF, 8,   0};
        tbl[1] = '{0, 14'h2000, 14'h1FFF, 1,   0, 0, 1, 32'h0000_FFFF, 1,   0};
        tbl[2] = '{1, 14'h0005, 14'h3FFF, 4,   2, 0, 1, 32'hE000_1FFA, 4,   0};
        tbl[3] = '{1, 14'h0000, 14'h3FFF, 32,  0, 1, 1, 32'hE000_1FFF, 32,  1};
        tbl[4] = '{0, 14'h1FFF, 14'h2000, 0,   5, 0, 1, 32'hFFFF_0000, 1,   0};
        tbl[5] = '{2, 14'h0000, 14'h0000, 100, 1, 2, 0, 32'h0,         100, 2};

        model_reset();
        m_acc = 0; m_lasts = 0; first_step = -1;
        @(negedge clk);
        chk("reset_tvalid", 64'(tvalid), 64'd0);
        chk("reset_tdata", 64'(tdata), 64'd0);
        chk("reset_tlast", 64'(tlast), 64'd0);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_frame(tbl[i]);

        // arm pulsed while draining a single-beat frame is ignored
        m_acc = 0; m_lasts = 0; first_step = -1;
        frame_len = 16'd0; decim = 16'd0; tready = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        frame_len = 16'd5; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("drain_busy", 64'(busy), 64'd1);
        tready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("drain_beats", 64'(m_acc), 64'd1);
        chk("drain_idle", 64'(busy), 64'd0);

        // asynchronous reset in the middle of a stalled, overflowing frame
        frame_len = 16'd40; tready = 1'b0; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 24; i++) tick();
        chk("pre_reset_tvalid", 64'(tvalid), 64'd1);
        chk("pre_reset_ovf", 64'(ovf), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_frame(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
